// File: rtl/alu_multipass_unit_pkg.sv
// rtl/alu_multipass_unit_pkg.sv - op codes, FSM states and pass-order helper for the multi-pass ALU
package alu_multipass_unit_pkg;

  localparam logic [2:0] kALU_ORA  = 3'd0;
  localparam logic [2:0] kALU_ORA2 = 3'd1;
  localparam logic [2:0] kALU_AND  = 3'd2;
  localparam logic [2:0] kALU_EOR  = 3'd3;
  localparam logic [2:0] kALU_ADC  = 3'd4;
  localparam logic [2:0] kALU_SHR  = 3'd5;
  localparam logic [2:0] kALU_ASR  = 3'd6;
  localparam logic [2:0] kALU_SHL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Right shifts walk from the top slice down so the shift-in bit enters at the MSB.
  function automatic logic high_first(input logic [2:0] op);
    return (op == kALU_SHR) || (op == kALU_ASR);
  endfunction

endpackage

// File: rtl/alu_multipass_unit_if.sv
// rtl/alu_multipass_unit_if.sv - start/busy/done request and result bundle for the multi-pass ALU
interface alu_multipass_unit_if #(
  parameter int OPERAND_W = 16
) ();

  logic                 start;
  logic [2:0]           op;
  logic [OPERAND_W-1:0] a;
  logic [OPERAND_W-1:0] b;
  logic                 c_in;
  logic                 dec_add;
  logic                 dec_sub;
  logic                 busy;
  logic                 done;
  logic [OPERAND_W-1:0] result;
  logic                 carry_out;
  logic                 overflow_out;
  logic                 z_out;
  logic                 n_out;

  modport master (
    output start, op, a, b, c_in, dec_add, dec_sub,
    input  busy, done, result, carry_out, overflow_out, z_out, n_out
  );

  modport slave (
    input  start, op, a, b, c_in, dec_add, dec_sub,
    output busy, done, result, carry_out, overflow_out, z_out, n_out
  );

endinterface

// File: rtl/alu_multipass_unit_slice.sv
// rtl/alu_multipass_unit_slice.sv - combinational SLICE_W pass; BCD adjust built only with ALU_MULTIPASS_DECIMAL_EN
module alu_slice_unit
  import alu_multipass_unit_pkg::*;
#(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic [2:0]         op_i,
  input  logic               c_i,
  input  logic               dec_add_i,
  input  logic               dec_sub_i,
  output logic [SLICE_W-1:0] res_o,
  output logic               c_o,
  output logic               v_o,
  output logic               z_o
);

  logic [SLICE_W-1:0] sum;
  logic               add_c;
  logic [4:0]         nib_sum;
  logic               nib_c;
  logic [3:0]         nib_res;

`ifndef ALU_MULTIPASS_DECIMAL_EN
  logic unused_dec;
  assign unused_dec = dec_add_i | dec_sub_i;
`endif

  always_comb begin
    sum     = '0;
    add_c   = c_i;
    nib_sum = '0;
    nib_c   = 1'b0;
    nib_res = '0;
    for (int n = 0; n < SLICE_W / 4; n++) begin
      nib_sum = {1'b0, a_i[n*4 +: 4]} + {1'b0, b_i[n*4 +: 4]} + {4'b0, add_c};
      nib_res = nib_sum[3:0];
`ifdef ALU_MULTIPASS_DECIMAL_EN
      nib_c = nib_sum[4] | (dec_add_i && (nib_sum > 5'd9));
      if (dec_add_i && nib_c) begin
        nib_res = nib_res + 4'd6;
      end else if (dec_sub_i && !nib_c) begin
        nib_res = nib_res + 4'hA;
      end
`else
      nib_c = nib_sum[4];
`endif
      sum[n*4 +: 4] = nib_res;
      add_c         = nib_c;
    end
  end

  always_comb begin
    res_o = '0;
    c_o   = add_c;
    case (op_i)
      kALU_ORA, kALU_ORA2: res_o = a_i | b_i;
      kALU_AND:            res_o = a_i & b_i;
      kALU_EOR:            res_o = a_i ^ b_i;
      kALU_ADC:            res_o = sum;
      kALU_SHR, kALU_ASR: begin
        res_o = {c_i, a_i[SLICE_W-1:1]};
        c_o   = a_i[0];
      end
      kALU_SHL: begin
        res_o = {a_i[SLICE_W-2:0], c_i};
        c_o   = a_i[SLICE_W-1];
      end
      default:             res_o = '0;
    endcase
    v_o = (a_i[SLICE_W-1] == b_i[SLICE_W-1]) && (a_i[SLICE_W-1] != res_o[SLICE_W-1]);
    z_o = (res_o == '0);
  end

endmodule

// File: rtl/alu_multipass_unit.sv
// rtl/alu_multipass_unit.sv - multi-pass 65xx ALU top: FSM, pass counter, operand/result shifters, flag chains
// Optional BCD adjust: define ALU_MULTIPASS_DECIMAL_EN.
module alu_multipass_unit
  import alu_multipass_unit_pkg::*;
#(
  parameter int OPERAND_W = 16,
  parameter int SLICE_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_multipass_unit_if.slave  bus
);

  localparam int PASSES = OPERAND_W / SLICE_W;
  localparam int CNT_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic [2:0]           op_q, op_d;
  logic                 dec_add_q, dec_add_d;
  logic                 dec_sub_q, dec_sub_d;
  logic                 chain_q, chain_d;
  logic                 zacc_q, zacc_d;
  logic                 vtop_q, vtop_d;
  logic [OPERAND_W-1:0] work_q, work_d;
  logic [OPERAND_W-1:0] result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 ovf_q, ovf_d;
  logic                 z_q, z_d;

  logic                 hf;
  logic                 top_slice;
  logic [SLICE_W-1:0]   slice_a, slice_b, slice_res;
  logic                 slice_c, slice_v, slice_z;
  logic [OPERAND_W+SLICE_W-1:0] cat_lo, cat_hi;

  assign hf        = high_first(op_q);
  assign slice_a   = hf ? a_q[OPERAND_W-1 -: SLICE_W] : a_q[SLICE_W-1:0];
  assign slice_b   = hf ? b_q[OPERAND_W-1 -: SLICE_W] : b_q[SLICE_W-1:0];
  assign top_slice = hf ? (cnt_q == '0) : (cnt_q == LAST_PASS);
  assign cat_lo    = {slice_res, work_q};
  assign cat_hi    = {work_q, slice_res};

  alu_slice_unit #(.SLICE_W(SLICE_W)) u_slice (
    .a_i       (slice_a),
    .b_i       (slice_b),
    .op_i      (op_q),
    .c_i       (chain_q),
    .dec_add_i (dec_add_q),
    .dec_sub_i (dec_sub_q),
    .res_o     (slice_res),
    .c_o       (slice_c),
    .v_o       (slice_v),
    .z_o       (slice_z)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= kALU_ORA;
      dec_add_q <= 1'b0;
      dec_sub_q <= 1'b0;
      chain_q   <= 1'b0;
      zacc_q    <= 1'b0;
      vtop_q    <= 1'b0;
      work_q    <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      z_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      dec_add_q <= dec_add_d;
      dec_sub_q <= dec_sub_d;
      chain_q   <= chain_d;
      zacc_q    <= zacc_d;
      vtop_q    <= vtop_d;
      work_q    <= work_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      z_q       <= z_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    dec_add_d = dec_add_q;
    dec_sub_d = dec_sub_q;
    chain_d   = chain_q;
    zacc_d    = zacc_q;
    vtop_d    = vtop_q;
    work_d    = work_q;
    result_d  = result_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    z_d       = z_q;

    case (state_q)
      ST_RUN: begin
        if (hf) begin
          a_d    = a_q << SLICE_W;
          b_d    = b_q << SLICE_W;
          work_d = cat_hi[OPERAND_W-1:0];
        end else begin
          a_d    = a_q >> SLICE_W;
          b_d    = b_q >> SLICE_W;
          work_d = cat_lo[OPERAND_W+SLICE_W-1:SLICE_W];
        end
        chain_d = slice_c;
        zacc_d  = zacc_q & slice_z;
        if (top_slice) begin
          vtop_d = slice_v;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_PASS) begin
          state_d  = ST_DONE;
          result_d = work_d;
          carry_d  = slice_c;
          ovf_d    = top_slice ? slice_v : vtop_q;
          z_d      = zacc_q & slice_z;
        end
      end
      default: begin
        // IDLE and DONE both accept, so a start in the done cycle chains back-to-back.
        state_d = ST_IDLE;
        if (bus.start) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          a_d       = bus.a;
          b_d       = bus.b;
          op_d      = bus.op;
          dec_add_d = bus.dec_add;
          dec_sub_d = bus.dec_sub;
          chain_d   = (bus.op == kALU_ASR) ? bus.a[OPERAND_W-1] : bus.c_in;
          zacc_d    = 1'b1;
          vtop_d    = 1'b0;
          work_d    = '0;
        end
      end
    endcase
  end

  assign bus.busy         = (state_q == ST_RUN);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.result       = result_q;
  assign bus.carry_out    = carry_q;
  assign bus.overflow_out = ovf_q;
  assign bus.z_out        = z_q;
  assign bus.n_out        = result_q[OPERAND_W-1];

endmodule

// File: tb/tb_alu_multipass_unit.sv
// tb/tb_alu_multipass_unit.sv - directed self-checking bench for alu_multipass_unit (16-bit, 8-bit slices)
module tb_alu_multipass_unit;
  import alu_multipass_unit_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_multipass_unit_if #(.OPERAND_W(16)) bus ();

  alu_multipass_unit #(.OPERAND_W(16), .SLICE_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request at a negedge, drops start after the accept edge and
  // returns cycles from accept to done (-1 when done never arrives).
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic da, input logic ds, output int lat);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    bus.c_in = c; bus.dec_add = da; bus.dec_sub = ds;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = kALU_ORA; bus.a = '0; bus.b = '0;
    bus.c_in = 1'b0; bus.dec_add = 1'b0; bus.dec_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++; $display("FAIL reset_handshake busy/done=%b expected 00", {bus.busy, bus.done});
    end
    checks++;
    if (bus.result !== 16'h0000) begin
      failures++; $display("FAIL reset_result got %h expected 0000", bus.result);
    end
    checks++;
    if ({bus.carry_out, bus.overflow_out, bus.z_out, bus.n_out} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags CVZN=%b expected 0000",
                           {bus.carry_out, bus.overflow_out, bus.z_out, bus.n_out});
    end
  endtask

  task automatic test_adc_binary();
    int lat;
    run_op(kALU_ADC, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      failures++; $display("FAIL adc_latency got %0d expected 2", lat);
    end
    checks++;
    if (bus.result !== 16'h1300) begin
      failures++; $display("FAIL adc_result got %h expected 1300", bus.result);
    end
    checks++;
    if ({bus.carry_out, bus.overflow_out, bus.z_out, bus.n_out} !== 4'b0000) begin
      failures++; $display("FAIL adc_flags CVZN=%b expected 0000",
                           {bus.carry_out, bus.overflow_out, bus.z_out, bus.n_out});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.result, bus.busy, bus.done} !== {16'h1300, 2'b00}) begin
      failures++; $display("FAIL adc_hold result=%h busy/done=%b expected 1300 00",
                           bus.result, {bus.busy, bus.done});
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(kALU_ADC, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.result, bus.carry_out, bus.overflow_out, bus.z_out, bus.n_out} !== {16'h8000, 4'b0101}) begin
      failures++; $display("FAIL adc_overflow result=%h CVZN=%b expected 8000 0101",
                           bus.result, {bus.carry_out, bus.overflow_out, bus.z_out, bus.n_out});
    end
  endtask

  task automatic test_decimal();
    int lat;
    logic [16:0] exp1, exp2, exp3;
    logic        expz2;
`ifdef ALU_MULTIPASS_DECIMAL_EN
    exp1 = {1'b0, 16'h1000}; exp2 = {1'b1, 16'h0000}; exp3 = {1'b1, 16'h0999}; expz2 = 1'b1;
`else
    exp1 = {1'b0, 16'h099A}; exp2 = {1'b0, 16'h999A}; exp3 = {1'b1, 16'h0FFF}; expz2 = 1'b0;
`endif
    run_op(kALU_ADC, 16'h0999, 16'h0001, 1'b0, 1'b1, 1'b0, lat);
    checks++;
    if ({bus.carry_out, bus.result} !== exp1) begin
      failures++; $display("FAIL dec_add_0999 C/result=%h expected %h", {bus.carry_out, bus.result}, exp1);
    end
    run_op(kALU_ADC, 16'h9999, 16'h0001, 1'b0, 1'b1, 1'b0, lat);
    checks++;
    if ({bus.carry_out, bus.result, bus.z_out} !== {exp2, expz2}) begin
      failures++; $display("FAIL dec_add_9999 C/result/Z=%h expected %h",
                           {bus.carry_out, bus.result, bus.z_out}, {exp2, expz2});
    end
    run_op(kALU_ADC, 16'h1000, 16'hFFFE, 1'b1, 1'b0, 1'b1, lat);
    checks++;
    if ({bus.carry_out, bus.result} !== exp3) begin
      failures++; $display("FAIL dec_sub C/result=%h expected %h", {bus.carry_out, bus.result}, exp3);
    end
  endtask

  task automatic test_shifts();
    int lat;
    run_op(kALU_SHR, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.result, bus.carry_out} !== {16'h8000, 1'b1}) begin
      failures++; $display("FAIL shr result=%h C=%b expected 8000 1", bus.result, bus.carry_out);
    end
    run_op(kALU_ASR, 16'h8002, 16'h0000, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.result, bus.carry_out} !== {16'hC001, 1'b0}) begin
      failures++; $display("FAIL asr result=%h C=%b expected c001 0", bus.result, bus.carry_out);
    end
    run_op(kALU_SHL, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.result, bus.carry_out, bus.z_out} !== {16'h0000, 2'b11}) begin
      failures++; $display("FAIL shl result=%h C=%b Z=%b expected 0000 1 1",
                           bus.result, bus.carry_out, bus.z_out);
    end
  endtask

  task automatic test_logic();
    int lat;
    run_op(kALU_ORA, 16'h0F0F, 16'h00F0, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.result, bus.carry_out} !== {16'h0FFF, 1'b0}) begin
      failures++; $display("FAIL ora result=%h C=%b expected 0fff 0", bus.result, bus.carry_out);
    end
    run_op(kALU_AND, 16'hFF00, 16'h0F0F, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.result, bus.carry_out} !== {16'h0F00, 1'b1}) begin
      failures++; $display("FAIL and result=%h C=%b expected 0f00 1", bus.result, bus.carry_out);
    end
    run_op(kALU_EOR, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.result, bus.carry_out, bus.n_out} !== {16'h5555, 2'b10}) begin
      failures++; $display("FAIL eor result=%h C=%b N=%b expected 5555 1 0",
                           bus.result, bus.carry_out, bus.n_out);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.op = kALU_ADC; bus.a = 16'h0001; bus.b = 16'h0001;
    bus.c_in = 1'b0; bus.dec_add = 1'b0; bus.dec_sub = 1'b0;
    @(posedge clk); #1;
    bus.op = kALU_EOR; bus.a = 16'h5555; bus.b = 16'h0F0F;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 2; n <= 20; n++) begin
      if (bus.done) begin
        lat = n - 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({lat == 2, bus.result} !== {1'b1, 16'h0002}) begin
      failures++; $display("FAIL ignore_start lat=%0d result=%h expected 2 0002", lat, bus.result);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      failures++; $display("FAIL ignore_start_idle busy/done=%b expected 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_reset_abort();
    int lat;
    logic saw_done;
    @(negedge clk);
    bus.start = 1'b1; bus.op = kALU_ADC; bus.a = 16'h1111; bus.b = 16'h2222;
    bus.c_in = 1'b0; bus.dec_add = 1'b0; bus.dec_sub = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL abort_busy got %b expected 1", bus.busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({bus.busy, bus.done, bus.result, bus.carry_out, bus.z_out} !== {2'b00, 16'h0000, 2'b00}) begin
      failures++; $display("FAIL abort_state busy/done=%b result=%h C=%b Z=%b expected 00 0000 0 0",
                           {bus.busy, bus.done}, bus.result, bus.carry_out, bus.z_out);
    end
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      saw_done = saw_done | bus.done;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++; $display("FAIL abort_no_done saw done=%b expected 0", saw_done);
    end
    run_op(kALU_ADC, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({lat == 2, bus.result} !== {1'b1, 16'h3333}) begin
      failures++; $display("FAIL abort_recover lat=%0d result=%h expected 2 3333", lat, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(kALU_ADC, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({lat == 2, bus.result} !== {1'b1, 16'h0002}) begin
      failures++; $display("FAIL b2b_first lat=%0d result=%h expected 2 0002", lat, bus.result);
    end
    run_op(kALU_EOR, 16'hF0F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, lat);
    checks++;
    if ({lat, bus.result} !== {32'sd2, 16'hFF00}) begin
      failures++; $display("FAIL b2b_second lat=%0d result=%h expected 2 ff00", lat, bus.result);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_adc_binary();
    test_overflow();
    test_decimal();
    test_shifts();
    test_logic();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
